// File: rtl/blackjack_pkg.sv
// blackjack_pkg: shared deck constants and card types
package blackjack_pkg;
  localparam int DECK_SIZE = 52;
  localparam int SUIT_SIZE = 13;
  localparam int FACE_POINTS = 10;
  typedef logic [5:0] card_idx_t;
  typedef logic [3:0] rank_t;
  typedef logic [1:0] suit_t;
  typedef enum logic {IDLE, SEARCH} dealer_state_t;
endpackage

// File: rtl/card_decode.sv
// card_decode: card index to rank, suit and blackjack points
module card_decode
  import blackjack_pkg::*;
(
  input  logic [5:0] idx,
  output logic [3:0] rank,
  output logic [1:0] suit,
  output logic [3:0] points
);
  assign rank = rank_t'(idx % 6'(SUIT_SIZE)) + 4'd1;
  assign suit = suit_t'(idx / 6'(SUIT_SIZE));
  assign points = rank > 4'(FACE_POINTS) ? 4'(FACE_POINTS) : rank;
endmodule

// File: rtl/card_dealer.sv
// card_dealer: draws cards without replacement by probing a dealt-card bitmap
module card_dealer
  import blackjack_pkg::*;
#(
  parameter int RAND_WIDTH = 6
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [RAND_WIDTH-1:0] i_rand,
  input  logic                  i_deal,
  input  logic                  i_shuffle,
  output logic                  o_busy,
  output logic                  o_valid,
  output logic [5:0]            o_card,
  output logic [3:0]            o_rank,
  output logic [1:0]            o_suit,
  output logic [3:0]            o_points,
  output logic [5:0]            o_cardsLeft,
  output logic                  o_deckEmpty,
  output logic                  o_error
);
  dealer_state_t state, state_n;
  logic [DECK_SIZE-1:0] dealt;
  card_idx_t idx;
  logic [5:0] cards_left;
  logic [RAND_WIDTH-1:0] rand_mod;
  logic take, found, err;
  rank_t rank_d, points_d;
  suit_t suit_d;
  assign rand_mod = i_rand % RAND_WIDTH'(DECK_SIZE);
  assign o_busy = state == SEARCH;
  assign o_cardsLeft = cards_left;
  assign o_deckEmpty = cards_left == 6'd0;
  card_decode u_decode (
    .idx   (idx),
    .rank  (rank_d),
    .suit  (suit_d),
    .points(points_d)
  );
  always_comb begin
    take = 1'b0;
    found = 1'b0;
    err = 1'b0;
    state_n = state;
    if (state == IDLE) begin
      err = !i_shuffle && i_deal && cards_left == 6'd0;
      take = !i_shuffle && i_deal && cards_left != 6'd0;
      state_n = take ? SEARCH : IDLE;
    end else begin
      found = !i_shuffle && !dealt[idx];
      state_n = (i_shuffle || found) ? IDLE : SEARCH;
    end
  end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      dealt <= '0;
      idx <= '0;
      cards_left <= 6'(DECK_SIZE);
      o_valid <= 1'b0;
      o_error <= 1'b0;
      o_card <= '0;
      o_rank <= '0;
      o_suit <= '0;
      o_points <= '0;
    end else begin
      o_valid <= found;
      o_error <= err;
      if (i_shuffle) begin
        dealt <= '0;
        cards_left <= 6'(DECK_SIZE);
      end else if (found) begin
        dealt[idx] <= 1'b1;
        cards_left <= cards_left - 6'd1;
        o_card <= idx;
        o_rank <= rank_d;
        o_suit <= suit_d;
        o_points <= points_d;
      end
      // probe forward with wrap while the slot under idx is taken
      if (take) idx <= card_idx_t'(rand_mod);
      else if (o_busy && !found && !i_shuffle) idx <= idx == 6'(DECK_SIZE - 1) ? 6'd0 : idx + 6'd1;
    end
  end
endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer: randomized and directed checks against a deck-level model
module tb_card_dealer;
  logic i_clk = 1'b0, i_reset = 1'b1, i_deal = 1'b0, i_shuffle = 1'b0;
  logic [5:0] i_rand = '0;
  logic o_busy, o_valid, o_deckEmpty, o_error;
  logic [5:0] o_card, o_cardsLeft;
  logic [3:0] o_rank, o_points;
  logic [1:0] o_suit;
  int n_cmp = 0, n_err = 0;
  bit dealt_m[52];
  int left_m = 52;
  always #5 i_clk = ~i_clk;
  card_dealer #(.RAND_WIDTH(6)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_rand(i_rand), .i_deal(i_deal), .i_shuffle(i_shuffle),
    .o_busy(o_busy), .o_valid(o_valid), .o_card(o_card), .o_rank(o_rank), .o_suit(o_suit),
    .o_points(o_points), .o_cardsLeft(o_cardsLeft), .o_deckEmpty(o_deckEmpty), .o_error(o_error)
  );
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic model_reset();
    foreach (dealt_m[i]) dealt_m[i] = 1'b0;
    left_m = 52;
  endtask
  task automatic deal(input int r, input string tag, output int card);
    int idx, p, busy_n, k;
    card = -1;
    @(negedge i_clk);
    i_rand = 6'(r);
    i_deal = 1'b1;
    @(posedge i_clk);
    #1 i_deal = 1'b0;
    if (left_m == 0) begin
      @(negedge i_clk);
      check({tag, ".error"}, 32'(o_error), 1);
      check({tag, ".novalid"}, 32'(o_valid), 0);
      check({tag, ".nobusy"}, 32'(o_busy), 0);
      @(negedge i_clk);
      check({tag, ".error_pulse"}, 32'(o_error), 0);
      return;
    end
    idx = r % 52;
    p = 0;
    while (dealt_m[idx]) begin
      idx = (idx + 1) % 52;
      p++;
    end
    dealt_m[idx] = 1'b1;
    left_m--;
    busy_n = 0;
    for (k = 0; k < 60; k++) begin
      @(negedge i_clk);
      if (o_valid) break;
      busy_n += int'(o_busy);
    end
    card = int'(o_card);
    check({tag, ".valid"}, 32'(o_valid), 1);
    check({tag, ".busy_cycles"}, busy_n, p + 1);
    check({tag, ".busy_low"}, 32'(o_busy), 0);
    check({tag, ".card"}, 32'(o_card), idx);
    check({tag, ".rank"}, 32'(o_rank), idx % 13 + 1);
    check({tag, ".suit"}, 32'(o_suit), idx / 13);
    check({tag, ".points"}, 32'(o_points), (idx % 13 + 1) > 10 ? 10 : idx % 13 + 1);
    check({tag, ".left"}, 32'(o_cardsLeft), left_m);
    check({tag, ".empty"}, 32'(o_deckEmpty), left_m == 0);
    @(negedge i_clk);
    check({tag, ".valid_pulse"}, 32'(o_valid), 0);
  endtask
  task automatic shuffle(input bit with_deal, input string tag);
    @(negedge i_clk);
    i_shuffle = 1'b1;
    i_deal = with_deal;
    i_rand = 6'($urandom_range(0, 63));
    @(posedge i_clk);
    #1 i_shuffle = 1'b0;
    i_deal = 1'b0;
    model_reset();
    @(negedge i_clk);
    check({tag, ".left"}, 32'(o_cardsLeft), 52);
    check({tag, ".busy"}, 32'(o_busy), 0);
    check({tag, ".valid"}, 32'(o_valid), 0);
  endtask
  task automatic start_search(input int r);
    @(negedge i_clk);
    i_rand = 6'(r);
    i_deal = 1'b1;
    @(posedge i_clk);
    #1 i_deal = 1'b0;
  endtask
  initial begin
    int c, seen;
    model_reset();
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    @(negedge i_clk);
    check("rst.busy", 32'(o_busy), 0);
    check("rst.valid", 32'(o_valid), 0);
    check("rst.card", 32'(o_card), 0);
    check("rst.rank", 32'(o_rank), 0);
    check("rst.suit", 32'(o_suit), 0);
    check("rst.points", 32'(o_points), 0);
    check("rst.left", 32'(o_cardsLeft), 52);
    check("rst.empty", 32'(o_deckEmpty), 0);
    check("rst.error", 32'(o_error), 0);
    deal(0, "d0", c);
    check("plan.card0", c, 0);
    deal(63, "d63", c);
    check("plan.card11", c, 11);
    deal(11, "d11", c);
    check("plan.card12", c, 12);
    shuffle(0, "sh1");
    deal(51, "wrap1", c);
    check("plan.card51", c, 51);
    deal(51, "wrap2", c);
    check("plan.wrap0", c, 0);
    shuffle(1, "sh_deal");
    for (int i = 0; i < 52; i++) begin
      deal(5, "exh", c);
      check("exh.order", c, (5 + i) % 52);
    end
    check("exh.empty", 32'(o_deckEmpty), 1);
    check("exh.left", 32'(o_cardsLeft), 0);
    deal(5, "exh53", c);
    shuffle(0, "sh2");
    for (int i = 0; i < 20; i++) deal(0, "fill", c);
    start_search(0);
    repeat (5) @(negedge i_clk);
    check("abort.busy_mid", 32'(o_busy), 1);
    i_shuffle = 1'b1;
    @(posedge i_clk);
    #1 i_shuffle = 1'b0;
    model_reset();
    @(negedge i_clk);
    check("abort.busy", 32'(o_busy), 0);
    check("abort.left", 32'(o_cardsLeft), 52);
    seen = 0;
    repeat (25) begin
      seen += int'(o_valid);
      @(negedge i_clk);
    end
    check("abort.novalid", seen, 0);
    for (int i = 0; i < 20; i++) deal(0, "fill2", c);
    start_search(0);
    repeat (3) @(negedge i_clk);
    #2 i_reset = 1'b1;
    #1;
    check("arst.busy", 32'(o_busy), 0);
    check("arst.left", 32'(o_cardsLeft), 52);
    check("arst.card", 32'(o_card), 0);
    @(negedge i_clk);
    i_reset = 1'b0;
    model_reset();
    deal(7, "arst.d7", c);
    check("plan.card7", c, 7);
    repeat (150) begin
      if (left_m == 0 ? $urandom_range(0, 1) == 1 : $urandom_range(0, 15) == 0)
        shuffle(1'($urandom_range(0, 1)), "rnd.sh");
      else
        deal($urandom_range(0, 63), "rnd", c);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
